// File: rtl/interlaken_seq_pkg.sv
// Shared types and helpers for the Interlaken test sequencer.
package interlaken_seq_pkg;

    // Widest core count the sequencer supports; narrower masks are zero-padded.
    localparam int MAX_CORES = 8;

    typedef enum logic [3:0] {
        S_GT_LOCK_WAIT  = 4'd0,
        S_RX_ALIGN_WAIT = 4'd1,
        S_SEND          = 4'd2,
        S_RECEIVE       = 4'd3,
        S_ROUND_END     = 4'd4,
        S_RESTART_WAIT  = 4'd5,
        S_RESTART       = 4'd6,
        S_BUSY_WAIT     = 4'd7,
        S_DONE_WAIT     = 4'd8,
        S_DONE          = 4'd9,
        S_ERROR         = 4'd10,
        S_RERUN         = 4'd11
    } seq_state_t;

    // True when every enabled core reports x; disabled cores count as satisfied.
    function automatic logic all_of(input logic [MAX_CORES-1:0] x,
                                    input logic [MAX_CORES-1:0] en);
        return &(x | ~en);
    endfunction

    // True when at least one enabled core reports x.
    function automatic logic any_of(input logic [MAX_CORES-1:0] x,
                                    input logic [MAX_CORES-1:0] en);
        return |(x & en);
    endfunction

endpackage

// File: rtl/interlaken_test_sequencer_watchdog.sv
// Per-state watchdog: clears on every state change, flags the cycle in
// which the count reaches all-ones (cycle 2^WIDTH-1 spent in one state).
module interlaken_seq_watchdog #(
    parameter int WIDTH = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Requires WIDTH >= 2; TERM is the count that becomes all-ones this cycle.
    localparam logic [WIDTH-1:0] TERM = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] count;

    // Up-count while enabled, holding at all-ones so it never wraps.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TERM);

endmodule

// File: rtl/interlaken_test_sequencer.sv
// Run controller for the Interlaken latency-measurement top level.
//
//   state            | meaning
//   -----------------+---------------------------------------------------
//   GT_LOCK_WAIT     | wait for all enabled cores to report GT lock
//   RX_ALIGN_WAIT    | wait for all enabled cores to report RX alignment
//   SEND             | packet generator running, wait for tx_done
//   RECEIVE          | wait for rx_done, latency still counting
//   ROUND_END        | one cycle: pm tick, round count advance
//   RESTART_WAIT     | wait for all cores to go idle
//   RESTART          | one cycle restart pulse to the exdes
//   BUSY_WAIT        | wait for all cores to pick up the restart
//   DONE_WAIT        | last round finished, wait for idle
//   DONE             | run passed, wait for run_start
//   ERROR            | run failed or timed out, wait for run_start
//   RERUN            | hold sys_reset for RST_CYCLES, then start over
module interlaken_test_sequencer
    import interlaken_seq_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int NUM_ROUNDS = 2,
    parameter int TIMEOUT_W  = 20,
    parameter int LAT_W      = 16,
    parameter int RST_CYCLES = 16
) (
    input  logic                 init_clk,
    input  logic                 clk_reset,
    input  logic [NUM_CORES-1:0] core_en,
    input  logic                 run_start,
    input  logic [NUM_CORES-1:0] tx_done,
    input  logic [NUM_CORES-1:0] tx_busy,
    input  logic [NUM_CORES-1:0] tx_fail,
    input  logic [NUM_CORES-1:0] rx_gt_locked,
    input  logic [NUM_CORES-1:0] rx_aligned,
    input  logic [NUM_CORES-1:0] rx_done,
    input  logic [NUM_CORES-1:0] rx_failed,
    input  logic [NUM_CORES-1:0] rx_busy,
    output logic                 sys_reset,
    output logic                 lbus_tx_rx_restart_in,
    output logic                 s_axi_pm_tick,
    output logic [3:0]           state,
    output logic [7:0]           round_cnt,
    output logic [LAT_W-1:0]     last_latency,
    output logic [LAT_W-1:0]     max_latency,
    output logic                 run_done,
    output logic                 run_pass,
    output logic                 timed_out,
    output logic [3:0]           fail_state
);

    localparam int               RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

    seq_state_t           state_q;
    seq_state_t           state_next;
    logic [NUM_CORES-1:0] en_q;
    logic [RST_W-1:0]     rst_cnt_q;
    logic [LAT_W-1:0]     latency_q;
    logic [LAT_W-1:0]     lat_inc;
    logic                 timeout_hit;
    logic                 wd_expired;
    logic                 wd_clear;
    logic                 wd_enable;

    function automatic logic [MAX_CORES-1:0] widen(input logic [NUM_CORES-1:0] v);
        widen = '0;
        widen[NUM_CORES-1:0] = v;
    endfunction

    logic [MAX_CORES-1:0] en_w;
    logic locked_all, aligned_all, tx_done_all, rx_done_all;
    logic busy_all, idle_all, fail_any, round_last;

    assign en_w        = widen(en_q);
    assign locked_all  = all_of(widen(rx_gt_locked), en_w);
    assign aligned_all = all_of(widen(rx_aligned), en_w);
    assign tx_done_all = all_of(widen(tx_done), en_w);
    assign rx_done_all = all_of(widen(rx_done), en_w);
    assign busy_all    = all_of(widen(tx_busy), en_w) & all_of(widen(rx_busy), en_w);
    assign idle_all    = ~any_of(widen(tx_busy), en_w) & ~any_of(widen(rx_busy), en_w);
    assign fail_any    = any_of(widen(tx_fail), en_w) | any_of(widen(rx_failed), en_w);
    assign round_last  = (({1'b0, round_cnt} + 9'd1) == 9'(NUM_ROUNDS));

    // Latency figure includes the closing cycle, so it equals cycles spent in SEND+RECEIVE.
    assign lat_inc = (latency_q == '1) ? latency_q : latency_q + 1'b1;

    assign wd_clear  = (state_next != state_q);
    assign wd_enable = (state_q != S_DONE) && (state_q != S_ERROR);

    interlaken_seq_watchdog #(
        .WIDTH (TIMEOUT_W)
    ) u_watchdog (
        .clk     (init_clk),
        .reset   (clk_reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge init_clk) begin
        if (clk_reset) begin
            state_q <= S_GT_LOCK_WAIT;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic; failures beat done, normal progress beats the watchdog.
    always_comb begin
        state_next  = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_GT_LOCK_WAIT: begin
                if (en_q == '0)      state_next = S_ERROR;
                else if (locked_all) state_next = S_RX_ALIGN_WAIT;
            end
            S_RX_ALIGN_WAIT: if (aligned_all) state_next = S_SEND;
            S_SEND: begin
                if (fail_any)         state_next = S_ERROR;
                else if (tx_done_all) state_next = S_RECEIVE;
            end
            S_RECEIVE: begin
                if (fail_any)         state_next = S_ERROR;
                else if (rx_done_all) state_next = S_ROUND_END;
            end
            S_ROUND_END:    state_next = round_last ? S_DONE_WAIT : S_RESTART_WAIT;
            S_RESTART_WAIT: if (idle_all) state_next = S_RESTART;
            S_RESTART:      state_next = S_BUSY_WAIT;
            S_BUSY_WAIT:    if (busy_all) state_next = S_SEND;
            S_DONE_WAIT:    if (idle_all) state_next = S_DONE;
            S_DONE,
            S_ERROR:        if (run_start) state_next = S_RERUN;
            S_RERUN:        if (rst_cnt_q == '0) state_next = S_GT_LOCK_WAIT;
            default:        state_next = S_GT_LOCK_WAIT;
        endcase
        if ((state_next == state_q) && wd_expired) begin
            state_next  = S_ERROR;
            timeout_hit = 1'b1;
        end
    end

    // Moore pulse outputs decoded straight from the state register.
    always_comb begin
        lbus_tx_rx_restart_in = 1'b0;
        s_axi_pm_tick         = 1'b0;
        case (state_q)
            S_RESTART:   lbus_tx_rx_restart_in = 1'b1;
            S_ROUND_END: s_axi_pm_tick         = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

    // Enable mask, rerun timer, latency measurement and sticky run status.
    always_ff @(posedge init_clk) begin
        if (clk_reset) begin
            en_q         <= core_en;
            sys_reset    <= 1'b1;
            rst_cnt_q    <= '0;
            latency_q    <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            round_cnt    <= '0;
            run_done     <= 1'b0;
            run_pass     <= 1'b0;
            timed_out    <= 1'b0;
            fail_state   <= '0;
        end else begin
            sys_reset <= (state_next == S_RERUN);

            if ((state_next == S_RERUN) && (state_q != S_RERUN)) begin
                en_q         <= core_en;
                rst_cnt_q    <= RST_LOAD;
                latency_q    <= '0;
                last_latency <= '0;
                max_latency  <= '0;
                round_cnt    <= '0;
                run_done     <= 1'b0;
                run_pass     <= 1'b0;
                timed_out    <= 1'b0;
                fail_state   <= '0;
            end else if (state_q == S_RERUN) begin
                en_q <= core_en;
                if (rst_cnt_q != '0) rst_cnt_q <= rst_cnt_q - 1'b1;
            end

            if ((state_next == S_SEND) && (state_q != S_SEND)) begin
                latency_q <= '0;
            end else if ((state_q == S_SEND) || (state_q == S_RECEIVE)) begin
                latency_q <= lat_inc;
            end

            if ((state_q == S_RECEIVE) && (state_next == S_ROUND_END)) begin
                last_latency <= lat_inc;
                if (lat_inc > max_latency) max_latency <= lat_inc;
            end

            if (state_q == S_ROUND_END) round_cnt <= round_cnt + 8'd1;

            if ((state_next == S_ERROR) && (state_q != S_ERROR)) begin
                run_done   <= 1'b1;
                run_pass   <= 1'b0;
                timed_out  <= timeout_hit;
                fail_state <= state_q;
            end

            if ((state_q == S_DONE_WAIT) && (state_next == S_DONE)) begin
                run_done <= 1'b1;
                run_pass <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interlaken_test_sequencer.sv
// Directed bench: a cycle-level exdes model drives both sequencer instances.
module tb_interlaken_test_sequencer;
    import interlaken_seq_pkg::*;

    localparam int DLY = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [1:0] core_en = 2'b11;
    logic       run_start = 1'b0;
    logic [1:0] tx_done = '0, tx_busy = '0, tx_fail = '0;
    logic [1:0] rx_gt_locked = '0, rx_aligned = '0, rx_done = '0, rx_failed = '0, rx_busy = '0;

    logic        sysrst_a, restart_a, tick_a, done_a, pass_a, tout_a;
    logic [3:0]  state_a, fstate_a;
    logic [7:0]  round_a;
    logic [15:0] last_a, max_a;

    logic        sysrst_b, restart_b, tick_b, done_b, pass_b, tout_b;
    logic [3:0]  state_b, fstate_b;
    logic [7:0]  round_b;
    logic [3:0]  last_b, max_b;

    int checks = 0;
    int errors = 0;
    int restart_cnt_a = 0;
    int tick_cnt_a = 0;
    logic [15:0] seen_lat0 = '0;

    interlaken_test_sequencer #(
        .NUM_CORES(2), .NUM_ROUNDS(2), .TIMEOUT_W(6), .LAT_W(16), .RST_CYCLES(16)
    ) dut_a (
        .init_clk(clk), .clk_reset(rst_a), .core_en(core_en), .run_start(run_start),
        .tx_done(tx_done), .tx_busy(tx_busy), .tx_fail(tx_fail),
        .rx_gt_locked(rx_gt_locked), .rx_aligned(rx_aligned), .rx_done(rx_done),
        .rx_failed(rx_failed), .rx_busy(rx_busy),
        .sys_reset(sysrst_a), .lbus_tx_rx_restart_in(restart_a), .s_axi_pm_tick(tick_a),
        .state(state_a), .round_cnt(round_a), .last_latency(last_a), .max_latency(max_a),
        .run_done(done_a), .run_pass(pass_a), .timed_out(tout_a), .fail_state(fstate_a)
    );

    interlaken_test_sequencer #(
        .NUM_CORES(2), .NUM_ROUNDS(2), .TIMEOUT_W(8), .LAT_W(4), .RST_CYCLES(16)
    ) dut_b (
        .init_clk(clk), .clk_reset(rst_b), .core_en(core_en), .run_start(run_start),
        .tx_done(tx_done), .tx_busy(tx_busy), .tx_fail(tx_fail),
        .rx_gt_locked(rx_gt_locked), .rx_aligned(rx_aligned), .rx_done(rx_done),
        .rx_failed(rx_failed), .rx_busy(rx_busy),
        .sys_reset(sysrst_b), .lbus_tx_rx_restart_in(restart_b), .s_axi_pm_tick(tick_b),
        .state(state_b), .round_cnt(round_b), .last_latency(last_b), .max_latency(max_b),
        .run_done(done_b), .run_pass(pass_b), .timed_out(tout_b), .fail_state(fstate_b)
    );

    always @(negedge clk) begin
        if (restart_a) restart_cnt_a <= restart_cnt_a + 1;
        if (tick_a)    tick_cnt_a    <= tick_cnt_a + 1;
    end

    task automatic drive_idle();
        tx_done = '0; tx_busy = '0; tx_fail = '0;
        rx_gt_locked = '0; rx_aligned = '0; rx_done = '0; rx_failed = '0; rx_busy = '0;
        run_start = 1'b0;
    endtask

    task automatic apply_reset_a(input logic [1:0] en);
        drive_idle();
        core_en = en;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
    endtask

    // Exdes model: each wait is answered DLY cycles into the state, SEND/RECEIVE by the given delays.
    task automatic run_model(input bit which, input logic [1:0] mask, input int d_send,
                             input int d_recv0, input int d_recv1, input bit inject,
                             input logic [3:0] stop_at, output bit ok);
        logic [3:0] st;
        logic [3:0] prev;
        int k, rnd, budget;
        bit fin;
        prev = 4'hF; k = 0; rnd = 0; budget = 0; fin = 1'b0; ok = 1'b0;
        while (!fin && budget < 3000) begin
            @(negedge clk);
            budget++;
            st = which ? state_b : state_a;
            if (st != prev) begin k = 1; prev = st; end else k++;
            if (st == stop_at || st == S_DONE || st == S_ERROR) begin
                fin = 1'b1;
                ok  = 1'b1;
            end else begin
                case (st)
                    S_GT_LOCK_WAIT:  if (k >= DLY) rx_gt_locked = mask;
                    S_RX_ALIGN_WAIT: if (k >= DLY) rx_aligned = mask;
                    S_SEND: begin
                        tx_busy = mask; rx_busy = mask;
                        if (k >= d_send) tx_done = mask;
                    end
                    S_RECEIVE: begin
                        if (k >= ((rnd == 0) ? d_recv0 : d_recv1)) begin
                            rx_done = mask;
                            if (inject) rx_failed = 2'b10;
                        end
                    end
                    S_ROUND_END: begin
                        if (rnd == 0) seen_lat0 = which ? 16'(last_b) : last_a;
                        rnd++;
                    end
                    S_RESTART_WAIT, S_DONE_WAIT: begin
                        tx_done = '0; rx_done = '0;
                        if (k >= DLY) begin tx_busy = '0; rx_busy = '0; end
                    end
                    S_BUSY_WAIT: if (k >= DLY) begin tx_busy = mask; rx_busy = mask; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        core_en = 2'b11;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (state_a !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_a); end
        checks++; if (sysrst_a !== 1'b1) begin errors++; $display("FAIL reset_sys_reset: got %b expected 1", sysrst_a); end
        checks++;
        if ({done_a, pass_a, tout_a, restart_a, tick_a, round_a, fstate_a, last_a, max_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b pass=%b tout=%b rst=%b tick=%b round=%0d fstate=%0d last=%0d max=%0d expected all 0",
                     done_a, pass_a, tout_a, restart_a, tick_a, round_a, fstate_a, last_a, max_a);
        end
        rst_a = 1'b0;
        @(negedge clk);
        checks++; if (sysrst_a !== 1'b0) begin errors++; $display("FAIL reset_release_sys_reset: got %b expected 0", sysrst_a); end
        checks++; if (state_a !== 4'd0) begin errors++; $display("FAIL reset_release_state: got %0d expected 0", state_a); end
    endtask

    task automatic test_nominal();
        int r0, t0;
        bit ok;
        apply_reset_a(2'b11);
        r0 = restart_cnt_a; t0 = tick_cnt_a;
        run_model(1'b0, 2'b11, DLY, DLY, DLY, 1'b0, 4'hF, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nominal_budget: stuck in state %0d expected 9", state_a); end
        checks++; if (state_a !== 4'd9) begin errors++; $display("FAIL nominal_state: got %0d expected 9", state_a); end
        checks++; if (restart_cnt_a - r0 != 1) begin errors++; $display("FAIL nominal_restarts: got %0d expected 1", restart_cnt_a - r0); end
        checks++; if (tick_cnt_a - t0 != 2) begin errors++; $display("FAIL nominal_ticks: got %0d expected 2", tick_cnt_a - t0); end
        checks++; if ({done_a, pass_a, tout_a} !== 3'b110) begin errors++; $display("FAIL nominal_status: got done/pass/tout=%b%b%b expected 110", done_a, pass_a, tout_a); end
        checks++; if (round_a !== 8'd2) begin errors++; $display("FAIL nominal_rounds: got %0d expected 2", round_a); end
        checks++; if (last_a !== 16'd20) begin errors++; $display("FAIL nominal_last_latency: got %0d expected 20", last_a); end
        checks++; if (max_a !== 16'd20) begin errors++; $display("FAIL nominal_max_latency: got %0d expected 20", max_a); end
    endtask

    task automatic test_rerun();
        int n;
        drive_idle();
        core_en = 2'b01;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        checks++; if (state_a !== 4'd11) begin errors++; $display("FAIL rerun_state: got %0d expected 11", state_a); end
        checks++;
        if ({done_a, pass_a, tout_a, round_a, last_a, max_a} !== '0) begin
            errors++;
            $display("FAIL rerun_cleared: done=%b pass=%b tout=%b round=%0d last=%0d max=%0d expected all 0",
                     done_a, pass_a, tout_a, round_a, last_a, max_a);
        end
        n = 0;
        while (sysrst_a === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 16) begin errors++; $display("FAIL rerun_sys_reset_len: got %0d expected 16", n); end
        checks++; if (state_a !== 4'd0) begin errors++; $display("FAIL rerun_exit_state: got %0d expected 0", state_a); end
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        checks++; if (state_a !== 4'd0 || sysrst_a !== 1'b0) begin errors++; $display("FAIL run_start_ignored: got state=%0d sys_reset=%b expected 0/0", state_a, sysrst_a); end
    endtask

    task automatic test_core_mask();
        bit ok;
        run_model(1'b0, 2'b01, DLY, DLY, DLY, 1'b0, 4'hF, ok);
        checks++; if (!ok || state_a !== 4'd9) begin errors++; $display("FAIL mask_state: got %0d expected 9", state_a); end
        checks++; if (pass_a !== 1'b1 || done_a !== 1'b1) begin errors++; $display("FAIL mask_pass: got done/pass=%b%b expected 11", done_a, pass_a); end
        checks++; if (round_a !== 8'd2) begin errors++; $display("FAIL mask_rounds: got %0d expected 2", round_a); end
    endtask

    task automatic test_empty_mask();
        apply_reset_a(2'b00);
        @(negedge clk);
        checks++; if (state_a !== 4'd10) begin errors++; $display("FAIL empty_mask_state: got %0d expected 10", state_a); end
        checks++;
        if ({done_a, pass_a, tout_a, fstate_a} !== 7'b1000000) begin
            errors++;
            $display("FAIL empty_mask_status: got done=%b pass=%b tout=%b fstate=%0d expected 1/0/0/0", done_a, pass_a, tout_a, fstate_a);
        end
    endtask

    task automatic test_fail_trap();
        int t0;
        bit ok;
        apply_reset_a(2'b11);
        t0 = tick_cnt_a;
        run_model(1'b0, 2'b11, DLY, DLY, DLY, 1'b1, 4'hF, ok);
        checks++; if (!ok || state_a !== 4'd10) begin errors++; $display("FAIL trap_state: got %0d expected 10", state_a); end
        checks++; if (fstate_a !== 4'd3) begin errors++; $display("FAIL trap_fail_state: got %0d expected 3", fstate_a); end
        checks++; if ({done_a, pass_a, tout_a} !== 3'b100) begin errors++; $display("FAIL trap_status: got done/pass/tout=%b%b%b expected 100", done_a, pass_a, tout_a); end
        checks++; if (tick_cnt_a != t0) begin errors++; $display("FAIL trap_no_tick: got %0d ticks expected 0", tick_cnt_a - t0); end
    endtask

    task automatic test_watchdog();
        int n;
        apply_reset_a(2'b11);
        rx_gt_locked = 2'b11;
        n = 0;
        while (state_a !== 4'd1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (state_a !== 4'd1) begin errors++; $display("FAIL wd_enter_align: got %0d expected 1", state_a); end
        n = 0;
        while (state_a === 4'd1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 63) begin errors++; $display("FAIL wd_cycles: got %0d expected 63", n); end
        checks++; if (state_a !== 4'd10) begin errors++; $display("FAIL wd_state: got %0d expected 10", state_a); end
        checks++; if (tout_a !== 1'b1 || fstate_a !== 4'd1) begin errors++; $display("FAIL wd_status: got tout=%b fstate=%0d expected 1/1", tout_a, fstate_a); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        apply_reset_a(2'b11);
        run_model(1'b0, 2'b11, DLY, DLY, DLY, 1'b0, 4'd7, ok);
        checks++; if (!ok || state_a !== 4'd7) begin errors++; $display("FAIL midrun_reach_busy_wait: got %0d expected 7", state_a); end
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if (state_a !== 4'd0 || sysrst_a !== 1'b1 || restart_a !== 1'b0 || round_a !== 8'd0) begin
            errors++;
            $display("FAIL midrun_reset: got state=%0d sys_reset=%b restart=%b round=%0d expected 0/1/0/0",
                     state_a, sysrst_a, restart_a, round_a);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        drive_idle();
        core_en = 2'b11;
        @(negedge clk);
        rst_b = 1'b0;
        run_model(1'b1, 2'b11, 4, 30, 5, 1'b0, 4'hF, ok);
        checks++; if (!ok || state_b !== 4'd9) begin errors++; $display("FAIL sat_state: got %0d expected 9", state_b); end
        checks++; if (seen_lat0 !== 16'd15) begin errors++; $display("FAIL sat_round1_latency: got %0d expected 15", seen_lat0); end
        checks++; if (last_b !== 4'd9) begin errors++; $display("FAIL sat_round2_latency: got %0d expected 9", last_b); end
        checks++; if (max_b !== 4'd15) begin errors++; $display("FAIL sat_max_latency: got %0d expected 15", max_b); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rerun();
        test_core_mask();
        test_empty_mask();
        test_fail_trap();
        test_watchdog();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
